resq_dispatch_queue: RTL

RESQ_DISPATCH_QUEUE -- requirements
Module: resq_dispatch_queue

---
 rtl/resq_pkg.sv | 19 +
 rtl/resq_dispatch_queue_if.sv | 39 +++
 rtl/resq_prio_queue.sv | 108 ++++++++++
 rtl/resq_dispatch_queue.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/resq_pkg.sv
// Shared constants for the resource dispatch queue.
//   - default parameter values for the queue and its interface
//   - channel (resource) codes: food, shelter and the evac FIFO
package resq_pkg;

    localparam int ZONE_W_DEF     = 8;
    localparam int PRIO_W_DEF     = 2;
    localparam int NUM_PQ_DEF     = 2;
    localparam int DEPTH_DEF      = 4;
    localparam int EVAC_DEPTH_DEF = 4;
    localparam int AGE_LIMIT_DEF  = 8;

    localparam int RES_W_DEF = $clog2(NUM_PQ_DEF + 1);

    localparam logic [RES_W_DEF-1:0] RES_FOOD    = RES_W_DEF'(0);
    localparam logic [RES_W_DEF-1:0] RES_SHELTER = RES_W_DEF'(1);
    localparam logic [RES_W_DEF-1:0] RES_EVAC    = RES_W_DEF'(NUM_PQ_DEF);

endpackage

// File: rtl/resq_dispatch_queue_if.sv
// Producer/consumer bus of the dispatch queue.
//   master : request source and consumer (drives Insert, Zone, Priority,
//            Resource_line, Serve; observes ready/err, winner and status)
//   slave  : the dispatch queue itself
interface resq_dispatch_queue_if #(
    parameter int ZONE_W = resq_pkg::ZONE_W_DEF,
    parameter int PRIO_W = resq_pkg::PRIO_W_DEF,
    parameter int NUM_PQ = resq_pkg::NUM_PQ_DEF
);
    localparam int RES_W = $clog2(NUM_PQ + 1);

    logic              Insert;
    logic [ZONE_W-1:0] Zone;
    logic [PRIO_W-1:0] Priority;
    logic [RES_W-1:0]  Resource_line;
    logic              Insert_Ready;
    logic              Insert_Err;
    logic              Serve;
    logic              Out_Valid;
    logic [ZONE_W-1:0] Output_Zone;
    logic [PRIO_W-1:0] Output_Priority;
    logic [RES_W-1:0]  Output_Resource;
    logic              Output_Boost;
    logic [NUM_PQ:0]   Full;
    logic [NUM_PQ:0]   Empty;

    modport master (
        output Insert, Zone, Priority, Resource_line, Serve,
        input  Insert_Ready, Insert_Err, Out_Valid, Output_Zone,
               Output_Priority, Output_Resource, Output_Boost, Full, Empty
    );

    modport slave (
        input  Insert, Zone, Priority, Resource_line, Serve,
        output Insert_Ready, Insert_Err, Out_Valid, Output_Zone,
               Output_Priority, Output_Resource, Output_Boost, Full, Empty
    );

endinterface

// File: rtl/resq_prio_queue.sv
// One aging priority queue (slot array, not ordered).
//   clk, rst          : clock, async active-high reset
//   ins/ins_zone/prio : accepted insert, written into the lowest free slot
//   cancel/cancel_zone: drop every valid entry of that zone
//   pop               : remove the current winner
//   full, empty       : occupancy status
//   win_*             : highest effective priority entry, lowest slot on tie
module resq_prio_queue
    import resq_pkg::*;
#(
    parameter int ZONE_W    = ZONE_W_DEF,
    parameter int PRIO_W    = PRIO_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AGE_LIMIT = AGE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins,
    input  logic [ZONE_W-1:0] ins_zone,
    input  logic [PRIO_W-1:0] ins_prio,
    input  logic              cancel,
    input  logic [ZONE_W-1:0] cancel_zone,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic              win_valid,
    output logic [ZONE_W-1:0] win_zone,
    output logic [PRIO_W-1:0] win_prio,
    output logic              win_boost
);
    localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AGE_W  = $clog2(AGE_LIMIT + 1);
    // The counter wraps on the edge it would reach AGE_LIMIT, so one
    // boost happens every AGE_LIMIT waiting cycles.
    localparam logic [AGE_W-1:0]  AGE_TC   = AGE_W'(AGE_LIMIT - 1);
    localparam logic [PRIO_W-1:0] PRIO_MAX = '1;

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  boost;
    logic [ZONE_W-1:0] zone [DEPTH];
    logic [PRIO_W-1:0] prio [DEPTH];
    logic [AGE_W-1:0]  age  [DEPTH];

    logic [SLOT_W-1:0] free_slot;
    logic [SLOT_W-1:0] win_slot;
    logic [PRIO_W-1:0] best_prio;

    always_comb begin
        free_slot = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) free_slot = SLOT_W'(i);
        end
    end

    // Strict '>' keeps the lowest slot among equal priorities.
    always_comb begin
        win_valid = 1'b0;
        win_slot  = '0;
        best_prio = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (!win_valid || prio[i] > best_prio)) begin
                win_valid = 1'b1;
                win_slot  = SLOT_W'(i);
                best_prio = prio[i];
            end
        end
    end

    assign win_zone  = win_valid ? zone[win_slot] : '0;
    assign win_prio  = best_prio;
    assign win_boost = win_valid & boost[win_slot];
    assign full      = &valid;
    assign empty     = ~|valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            boost <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                zone[i] <= '0;
                prio[i] <= '0;
                age[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((pop && win_slot == SLOT_W'(i)) ||
                    (cancel && valid[i] && zone[i] == cancel_zone)) begin
                    valid[i] <= 1'b0;
                end else if (ins && !valid[i] && free_slot == SLOT_W'(i)) begin
                    valid[i] <= 1'b1;
                    zone[i]  <= ins_zone;
                    prio[i]  <= ins_prio;
                    boost[i] <= 1'b0;
                    age[i]   <= '0;
                end else if (valid[i]) begin
                    if (age[i] == AGE_TC) begin
                        age[i]   <= '0;
                        boost[i] <= 1'b1;
                        if (prio[i] != PRIO_MAX) prio[i] <= prio[i] + 1'b1;
                    end else begin
                        age[i] <= age[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/resq_dispatch_queue.sv
// Resource dispatch queue: NUM_PQ aging priority queues plus an evac FIFO
// that pre-empts them and cancels same-zone requests.
//   Clock, Reset_Queue : clock, async active-high reset
//   bus (slave)        : insert request / ready / err, serve strobe,
//                        current winner fields, per-channel Full/Empty
module resq_dispatch_queue
    import resq_pkg::*;
#(
    parameter int ZONE_W     = ZONE_W_DEF,
    parameter int PRIO_W     = PRIO_W_DEF,
    parameter int NUM_PQ     = NUM_PQ_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int EVAC_DEPTH = EVAC_DEPTH_DEF,
    parameter int AGE_LIMIT  = AGE_LIMIT_DEF
) (
    input  logic                 Clock,
    input  logic                 Reset_Queue,
    resq_dispatch_queue_if.slave bus
);
    localparam int RES_W = $clog2(NUM_PQ + 1);
    localparam int PTR_W = (EVAC_DEPTH > 1) ? $clog2(EVAC_DEPTH) : 1;
    localparam int CNT_W = $clog2(EVAC_DEPTH + 1);
    localparam logic [RES_W-1:0] EVAC_CODE = RES_W'(NUM_PQ);
    localparam logic [CNT_W-1:0] EV_MAX    = CNT_W'(EVAC_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(EVAC_DEPTH - 1);

    logic [NUM_PQ-1:0] pq_full, pq_empty, pq_sel, pq_ins, pq_pop;
    logic [NUM_PQ-1:0] pq_wvalid, pq_wboost;
    logic [ZONE_W-1:0] pq_wzone [NUM_PQ];
    logic [PRIO_W-1:0] pq_wprio [NUM_PQ];

    logic [ZONE_W-1:0]     ev_zone [EVAC_DEPTH];
    logic [EVAC_DEPTH-1:0] ev_valid;
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      ev_count;

    logic ev_full, ev_empty, sel_evac, evac_match, ready;
    logic accept_evac, accept_pq, pop, ev_pop, insert_err;
    logic              out_valid, out_boost;
    logic [ZONE_W-1:0] out_zone;
    logic [PRIO_W-1:0] out_prio;
    logic [RES_W-1:0]  out_res;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign ev_full  = (ev_count == EV_MAX);
    assign ev_empty = (ev_count == '0);
    assign sel_evac = (bus.Resource_line == EVAC_CODE);

    always_comb begin
        pq_sel = '0;
        for (int c = 0; c < NUM_PQ; c++) pq_sel[c] = (bus.Resource_line == RES_W'(c));
    end

    // Readiness uses pre-edge occupancy; forced low while reset is held.
    always_comb begin
        ready = 1'b0;
        if (!Reset_Queue) begin
            if (sel_evac) ready = !ev_full;
            for (int c = 0; c < NUM_PQ; c++) begin
                if (pq_sel[c]) ready = !pq_full[c];
            end
        end
    end

    always_comb begin
        evac_match = 1'b0;
        for (int j = 0; j < EVAC_DEPTH; j++) begin
            if (ev_valid[j] && ev_zone[j] == bus.Zone) evac_match = 1'b1;
        end
    end

    assign accept_evac = bus.Insert && ready && sel_evac;
    assign accept_pq   = bus.Insert && ready && !sel_evac && !evac_match;
    assign pq_ins      = accept_pq ? pq_sel : '0;

    // Evac head always wins; otherwise highest priority, lowest channel on tie.
    always_comb begin
        out_valid = 1'b0;
        out_zone  = '0;
        out_prio  = '0;
        out_res   = '0;
        out_boost = 1'b0;
        if (!ev_empty) begin
            out_valid = 1'b1;
            out_zone  = ev_zone[rd_ptr];
            out_res   = EVAC_CODE;
        end else begin
            for (int c = 0; c < NUM_PQ; c++) begin
                if (pq_wvalid[c] && (!out_valid || pq_wprio[c] > out_prio)) begin
                    out_valid = 1'b1;
                    out_zone  = pq_wzone[c];
                    out_prio  = pq_wprio[c];
                    out_res   = RES_W'(c);
                    out_boost = pq_wboost[c];
                end
            end
        end
    end

    assign pop    = bus.Serve && out_valid;
    assign ev_pop = pop && !ev_empty;

    always_comb begin
        pq_pop = '0;
        for (int c = 0; c < NUM_PQ; c++) pq_pop[c] = pop && ev_empty && (out_res == RES_W'(c));
    end

    for (genvar c = 0; c < NUM_PQ; c++) begin : g_pq
        resq_prio_queue #(
            .ZONE_W    (ZONE_W),
            .PRIO_W    (PRIO_W),
            .DEPTH     (DEPTH),
            .AGE_LIMIT (AGE_LIMIT)
        ) u_pq (
            .clk         (Clock),
            .rst         (Reset_Queue),
            .ins         (pq_ins[c]),
            .ins_zone    (bus.Zone),
            .ins_prio    (bus.Priority),
            .cancel      (accept_evac),
            .cancel_zone (bus.Zone),
            .pop         (pq_pop[c]),
            .full        (pq_full[c]),
            .empty       (pq_empty[c]),
            .win_valid   (pq_wvalid[c]),
            .win_zone    (pq_wzone[c]),
            .win_prio    (pq_wprio[c]),
            .win_boost   (pq_wboost[c])
        );
    end

    // A push and a pop never share a slot: a pop needs count > 0 and a
    // push needs count < EVAC_DEPTH, so the pointers differ.
    always_ff @(posedge Clock or posedge Reset_Queue) begin
        if (Reset_Queue) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            ev_count   <= '0;
            ev_valid   <= '0;
            insert_err <= 1'b0;
            for (int j = 0; j < EVAC_DEPTH; j++) ev_zone[j] <= '0;
        end else begin
            insert_err <= bus.Insert && !(accept_evac || accept_pq);
            if (accept_evac) begin
                ev_zone[wr_ptr]  <= bus.Zone;
                ev_valid[wr_ptr] <= 1'b1;
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (ev_pop) begin
                ev_valid[rd_ptr] <= 1'b0;
                rd_ptr           <= ptr_next(rd_ptr);
            end
            ev_count <= ev_count + CNT_W'(accept_evac) - CNT_W'(ev_pop);
        end
    end

    assign bus.Insert_Ready    = ready;
    assign bus.Insert_Err      = insert_err;
    assign bus.Out_Valid       = out_valid;
    assign bus.Output_Zone     = out_zone;
    assign bus.Output_Priority = out_prio;
    assign bus.Output_Resource = out_res;
    assign bus.Output_Boost    = out_boost;
    assign bus.Full            = {ev_full, pq_full};
    assign bus.Empty           = {ev_empty, pq_empty};

endmodule
